// File: rtl/my_mux_arb_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// The mux attaches through the slave modport; the driving environment uses master.
interface my_mux_arb_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/my_mux_arb.sv
// N-channel registered mux with valid/ready on every input and on the output.
// Channel choice is either an explicit select (mode=0) or round-robin (mode=1).
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_EMPTY | output register holds no undelivered word
//  ST_FULL  | out_data/out_chan hold a word awaiting out_ready
module my_mux_arb #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    my_mux_arb_if.slave   bus
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [SEL_W-1:0]   out_chan_q;
    logic [SEL_W-1:0]   last_q;

    logic               load_en;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    int                 rr_idx;
    logic [WIDTH-1:0]   sel_data_d;
    logic [CHANNELS-1:0] in_ready_c;

    // The register can take a new word when empty or when its word leaves this cycle.
    assign load_en = (state_q == ST_EMPTY) || bus.out_ready;

    // Grant selection: explicit select or round-robin search starting after last_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (!bus.mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // last_q < CHANNELS always, so one conditional subtract is a full mod.
            for (int k = 1; k <= CHANNELS; k++) begin
                rr_idx = int'(last_q) + k;
                if (rr_idx >= CHANNELS) begin
                    rr_idx = rr_idx - CHANNELS;
                end
                if (!grant_vld && bus.in_valid[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(rr_idx);
                end
            end
        end
    end

    // Data mux feeds only the output register, never an output port directly.
    always_comb begin
        sel_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data_d = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot acceptance strobe back to the granted producer; silent in reset.
    always_comb begin
        in_ready_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst_n && load_en && grant_vld && grant_idx == SEL_W'(i)) begin
                in_ready_c[i] = 1'b1;
            end
        end
    end

    // Output register FSM: load on grant, drain when nothing is granted, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_chan_q <= '0;
            last_q     <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                state_q    <= ST_FULL;
                out_data_q <= sel_data_d;
                out_chan_q <= grant_idx;
                last_q     <= grant_idx;
            end else begin
                state_q    <= ST_EMPTY;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_my_mux_arb.sv
// Bench for my_mux_arb: an 8-channel instance tracked cycle by cycle by a
// reference model with an expected-word queue, plus 10- and 5-channel
// instances for out-of-range select and non-power-of-2 wrap.
module tb_my_mux_arb;

    logic clk;
    logic rst_n;

    my_mux_arb_if #(.WIDTH(16), .CHANNELS(8))  bus ();
    my_mux_arb_if #(.WIDTH(16), .CHANNELS(10)) bus10 ();
    my_mux_arb_if #(.WIDTH(16), .CHANNELS(5))  bus5 ();

    my_mux_arb #(.WIDTH(16), .CHANNELS(8))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    my_mux_arb #(.WIDTH(16), .CHANNELS(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10.slave));
    my_mux_arb #(.WIDTH(16), .CHANNELS(5))  u_dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the 8-channel instance, evaluated between edges.
    bit          model_en = 1'b0;
    bit          m_full   = 1'b0;
    int          m_last   = 7;
    logic [18:0] m_q[$];

    always @(negedge clk) begin
        logic [7:0] exp_rdy;
        int         g;
        bit         ld;
        if (model_en) begin
            ld = !m_full || bus.out_ready;
            g  = -1;
            if (bus.mode == 1'b0) begin
                if (bus.in_valid[bus.sel]) g = int'(bus.sel);
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    if (g < 0 && bus.in_valid[(m_last + k) % 8]) g = (m_last + k) % 8;
                end
            end
            exp_rdy = (rst_n && ld && g >= 0) ? 8'(1 << g) : 8'h00;
            chk("m_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("m_valid", 32'(bus.out_valid), 32'(m_full));
            if (m_full && m_q.size() > 0) begin
                chk("m_data", 32'(bus.out_data), 32'(m_q[0][15:0]));
                chk("m_chan", 32'(bus.out_chan), 32'(m_q[0][18:16]));
            end
            if (!rst_n) begin
                m_full = 1'b0;
                m_last = 7;
                m_q.delete();
            end else begin
                if (m_full && bus.out_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (ld) begin
                    if (g >= 0) begin
                        m_q.push_back({3'(g), bus.in_data[g*16 +: 16]});
                        m_full = 1'b1;
                        m_last = g;
                    end else begin
                        m_full = 1'b0;
                    end
                end
            end
        end
    end

    int q5[$];

    initial begin
        int exp_c;
        int rr_exp[3];
        rr_exp[0] = 0; rr_exp[1] = 2; rr_exp[2] = 7;

        rst_n = 1'b0;
        bus.in_data = '0;   bus.in_valid = '0;   bus.mode = 1'b0;   bus.sel = '0;   bus.out_ready = 1'b0;
        bus10.in_data = '0; bus10.in_valid = '0; bus10.mode = 1'b0; bus10.sel = '0; bus10.out_ready = 1'b0;
        bus5.in_data = '0;  bus5.in_valid = '0;  bus5.mode = 1'b0;  bus5.sel = '0;  bus5.out_ready = 1'b0;

        // Reset then idle
        cyc();
        model_en = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data",  32'(bus.out_data),  32'h0);
        chk("rst_chan",  32'(bus.out_chan),  32'h0);
        chk("rst_rdy10", 32'(bus10.in_ready), 32'h0);
        chk("rst_rdy5",  32'(bus5.in_ready),  32'h0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_valid", 32'(bus.out_valid), 32'h0);
            chk("idle_data",  32'(bus.out_data),  32'h0);
            cyc();
        end

        // Five channels, round-robin between channels 0 and 4
        for (int i = 0; i < 5; i++) bus5.in_data[i*16 +: 16] = 16'(16'h5000 + i);
        bus5.mode = 1'b1; bus5.in_valid = 5'b10001; bus5.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp_c = q5.pop_front();
                chk("rr5_chan",  32'(bus5.out_chan),  32'(exp_c));
                chk("rr5_data",  32'(bus5.out_data),  32'(16'h5000 + exp_c));
                chk("rr5_valid", 32'(bus5.out_valid), 32'h1);
            end
            exp_c = (k % 2 == 0) ? 0 : 4;
            chk("rr5_ready", 32'(bus5.in_ready), 32'(1 << exp_c));
            q5.push_back(exp_c);
            cyc();
        end
        bus5.in_valid = '0;

        // Ten channels, fixed select
        for (int i = 0; i < 10; i++) bus10.in_data[i*16 +: 16] = 16'(16'h9000 + i);
        bus10.mode = 1'b0; bus10.sel = 4'd9; bus10.in_valid = 10'h1FF; bus10.out_ready = 1'b1;
        @(negedge clk);
        chk("sel9_nov_rdy", 32'(bus10.in_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk("sel9_nov_valid", 32'(bus10.out_valid), 32'h0);
        bus10.sel = 4'd12; bus10.in_valid = 10'h3FF;
        @(negedge clk);
        chk("sel12_rdy", 32'(bus10.in_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk("sel12_valid", 32'(bus10.out_valid), 32'h0);
        bus10.sel = 4'd9;
        @(negedge clk);
        chk("sel9_rdy", 32'(bus10.in_ready), 32'h200);
        cyc();
        @(negedge clk);
        chk("sel9_chan", 32'(bus10.out_chan), 32'h9);
        chk("sel9_data", 32'(bus10.out_data), 32'h9009);
        bus10.in_valid = '0;

        // Eight channels, fixed select of channel 5
        for (int i = 0; i < 8; i++) bus.in_data[i*16 +: 16] = 16'(16'h1000 + i);
        bus.in_data[5*16 +: 16] = 16'hA5A5;
        bus.mode = 1'b0; bus.sel = 3'd5; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fix_rdy", 32'(bus.in_ready), 32'h20);
            if (k > 0) begin
                chk("fix_data", 32'(bus.out_data), 32'hA5A5);
                chk("fix_chan", 32'(bus.out_chan), 32'h5);
            end
            cyc();
        end

        // Round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.mode = 1'b1; bus.in_valid = 8'b1000_0101;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("rr_chan",  32'(bus.out_chan),  32'(rr_exp[(k-1) % 3]));
                chk("rr_valid", 32'(bus.out_valid), 32'h1);
            end
            cyc();
        end

        // Backpressure with channel 3 holding 1234
        bus.mode = 1'b0; bus.sel = 3'd3; bus.in_valid = 8'h08;
        bus.in_data[3*16 +: 16] = 16'h1234;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_data[3*16 +: 16] = 16'h9999;
        bus.in_data[5*16 +: 16] = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            bus.sel = 3'($urandom_range(0, 7));
            bus.in_valid = 8'($urandom_range(0, 255));
            bus.mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_data",  32'(bus.out_data),  32'h1234);
            chk("bp_chan",  32'(bus.out_chan),  32'h3);
            chk("bp_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_rdy",   32'(bus.in_ready),  32'h0);
            cyc();
        end
        bus.mode = 1'b0; bus.sel = 3'd5; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_rdy",  32'(bus.in_ready), 32'h20);
        chk("bp_rel_hold", 32'(bus.out_data), 32'h1234);
        cyc();
        @(negedge clk);
        chk("bp_next_chan", 32'(bus.out_chan), 32'h5);
        chk("bp_next_data", 32'(bus.out_data), 32'hBEEF);

        // Reset in the middle of a round-robin stream
        bus.mode = 1'b1; bus.in_valid = 8'hFF;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", 32'(bus.in_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_data",  32'(bus.out_data),  32'h0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_first_rdy", 32'(bus.in_ready), 32'h01);
        cyc();
        @(negedge clk);
        chk("mid_first_chan", 32'(bus.out_chan),  32'h0);
        chk("mid_first_vld",  32'(bus.out_valid), 32'h1);
        bus.in_valid = '0;
        cyc(); cyc();

        model_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
